// File: rtl/rs_param.sv
// ---------------------------------------------------------------------------
// rs_param -- parameterized reservation station
//
// Holds up to N_ENTRY issued operations until both source operands are
// available, snooping N_CDB common-data-bus channels for tag wakeups, and
// dispatches the oldest ready entry to a functional unit.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             discard every entry (beats issue/wakeup/dispatch)
//   issue_valid       issue request; issue_ready = some entry is free
//   op_in .. dest_in  fields of the issued operation (q*_in == 0: ready)
//   cdb_valid/tag/data broadcast channels, channel c in slice c
//   fu_ready          functional unit accepts a dispatch this cycle
//   disp_valid, op_out .. dest_out  registered dispatch (zero when idle)
//   count             registered number of busy entries
// ---------------------------------------------------------------------------
module rs_param #(
    parameter int N_ENTRY = 4,
    parameter int OP_W    = 4,
    parameter int ROB_W   = 4,
    parameter int DATA_W  = 32,
    parameter int N_CDB   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [OP_W-1:0]              op_in,
    input  logic [DATA_W-1:0]            vj_in,
    input  logic [DATA_W-1:0]            vk_in,
    input  logic [DATA_W-1:0]            pc_in,
    input  logic [DATA_W-1:0]            imm_in,
    input  logic [ROB_W-1:0]             qj_in,
    input  logic [ROB_W-1:0]             qk_in,
    input  logic [ROB_W-1:0]             dest_in,
    input  logic [N_CDB-1:0]             cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]       cdb_tag,
    input  logic [N_CDB*DATA_W-1:0]      cdb_data,
    input  logic                         fu_ready,
    output logic                         disp_valid,
    output logic [OP_W-1:0]              op_out,
    output logic [DATA_W-1:0]            vj_out,
    output logic [DATA_W-1:0]            vk_out,
    output logic [DATA_W-1:0]            pc_out,
    output logic [DATA_W-1:0]            imm_out,
    output logic [ROB_W-1:0]             dest_out,
    output logic [$clog2(N_ENTRY+1)-1:0] count
);

    localparam int IDX_W = $clog2(N_ENTRY);
    localparam int AGE_W = $clog2(N_ENTRY);
    localparam int CNT_W = $clog2(N_ENTRY+1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(N_ENTRY - 1);

    // Entry storage
    logic [N_ENTRY-1:0]             busy;
    logic [N_ENTRY-1:0][OP_W-1:0]   op_q;
    logic [N_ENTRY-1:0][DATA_W-1:0] vj_q, vk_q, pc_q, imm_q;
    logic [N_ENTRY-1:0][ROB_W-1:0]  qj_q, qk_q, dest_q;
    logic [N_ENTRY-1:0][AGE_W-1:0]  age_q;

    // CDB lookup: returns {hit, data}. Scanning from the top channel down
    // lets the lowest matching channel overwrite last, so it wins. Tag 0
    // means "already ready" and never matches.
    function automatic logic [DATA_W:0] cdb_match(
        input logic [ROB_W-1:0]        tag,
        input logic [N_CDB-1:0]        vld,
        input logic [N_CDB*ROB_W-1:0]  tags,
        input logic [N_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        if (tag != '0) begin
            for (int c = N_CDB - 1; c >= 0; c--) begin
                if (vld[c] && tags[c*ROB_W +: ROB_W] == tag)
                    r = {1'b1, data[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    // Per-entry wakeup matches and readiness (registered state only, so a
    // wakeup this cycle makes the entry eligible next cycle).
    logic [N_ENTRY-1:0][DATA_W:0] wj, wk;
    logic [N_ENTRY-1:0]           rdy;

    for (genvar g = 0; g < N_ENTRY; g++) begin : g_ent
        assign wj[g]  = cdb_match(qj_q[g], cdb_valid, cdb_tag, cdb_data);
        assign wk[g]  = cdb_match(qk_q[g], cdb_valid, cdb_tag, cdb_data);
        assign rdy[g] = busy[g] && qj_q[g] == '0 && qk_q[g] == '0;
    end

    // Issue-time bypass for operands produced in the same cycle
    logic [DATA_W:0] bj, bk;
    assign bj = cdb_match(qj_in, cdb_valid, cdb_tag, cdb_data);
    assign bk = cdb_match(qk_in, cdb_valid, cdb_tag, cdb_data);

    // Lowest free entry
    logic [IDX_W-1:0] free_idx;
    always_comb begin
        free_idx = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--)
            if (!busy[i]) free_idx = IDX_W'(i);
    end

    assign issue_ready = ~&busy;

    // Oldest ready entry; strict '>' keeps ties on the lowest index
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [AGE_W-1:0] sel_age;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (rdy[i] && (!sel_found || age_q[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    logic issue_acc, disp_fire;
    assign issue_acc = issue_valid && issue_ready && !flush;
    assign disp_fire = fu_ready && sel_found && !flush;

    // Next busy vector and its population count. Issue only targets an
    // entry free at the start of the cycle, so it never collides with the
    // entry being dispatched.
    logic [N_ENTRY-1:0] busy_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    always_comb begin
        busy_nxt = busy;
        if (issue_acc) busy_nxt[free_idx] = 1'b1;
        if (disp_fire) busy_nxt[sel_idx]  = 1'b0;
        if (flush)     busy_nxt           = '0;
        cnt_nxt = '0;
        for (int i = 0; i < N_ENTRY; i++)
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            op_q       <= '0;
            vj_q       <= '0;
            vk_q       <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            qj_q       <= '0;
            qk_q       <= '0;
            dest_q     <= '0;
            age_q      <= '0;
            count      <= '0;
            disp_valid <= 1'b0;
            op_out     <= '0;
            vj_out     <= '0;
            vk_out     <= '0;
            pc_out     <= '0;
            imm_out    <= '0;
            dest_out   <= '0;
        end else begin
            busy  <= busy_nxt;
            count <= cnt_nxt;

            // Outputs read as zero unless a dispatch fires this edge
            disp_valid <= 1'b0;
            op_out     <= '0;
            vj_out     <= '0;
            vk_out     <= '0;
            pc_out     <= '0;
            imm_out    <= '0;
            dest_out   <= '0;

            if (!flush) begin
                for (int i = 0; i < N_ENTRY; i++) begin
                    if (busy[i]) begin
                        if (wj[i][DATA_W]) begin
                            vj_q[i] <= wj[i][DATA_W-1:0];
                            qj_q[i] <= '0;
                        end
                        if (wk[i][DATA_W]) begin
                            vk_q[i] <= wk[i][DATA_W-1:0];
                            qk_q[i] <= '0;
                        end
                        if (issue_acc && age_q[i] != AGE_MAX)
                            age_q[i] <= age_q[i] + 1'b1;
                    end
                end

                if (issue_acc) begin
                    op_q[free_idx]   <= op_in;
                    vj_q[free_idx]   <= bj[DATA_W] ? bj[DATA_W-1:0] : vj_in;
                    vk_q[free_idx]   <= bk[DATA_W] ? bk[DATA_W-1:0] : vk_in;
                    qj_q[free_idx]   <= bj[DATA_W] ? '0 : qj_in;
                    qk_q[free_idx]   <= bk[DATA_W] ? '0 : qk_in;
                    pc_q[free_idx]   <= pc_in;
                    imm_q[free_idx]  <= imm_in;
                    dest_q[free_idx] <= dest_in;
                    age_q[free_idx]  <= '0;
                end

                if (disp_fire) begin
                    disp_valid <= 1'b1;
                    op_out     <= op_q[sel_idx];
                    vj_out     <= vj_q[sel_idx];
                    vk_out     <= vk_q[sel_idx];
                    pc_out     <= pc_q[sel_idx];
                    imm_out    <= imm_q[sel_idx];
                    dest_out   <= dest_q[sel_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_param.sv
// ---------------------------------------------------------------------------
// tb_rs_param -- directed self-checking bench for rs_param (default params)
// ---------------------------------------------------------------------------
module tb_rs_param;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, issue_ready, fu_ready;
    logic [3:0]  op_in, qj_in, qk_in, dest_in;
    logic [31:0] vj_in, vk_in, pc_in, imm_in;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        disp_valid;
    logic [3:0]  op_out, dest_out;
    logic [31:0] vj_out, vk_out, pc_out, imm_out;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    rs_param dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op_in(op_in), .vj_in(vj_in), .vk_in(vk_in), .pc_in(pc_in),
        .imm_in(imm_in), .qj_in(qj_in), .qk_in(qk_in), .dest_in(dest_in),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_ready(fu_ready), .disp_valid(disp_valid), .op_out(op_out),
        .vj_out(vj_out), .vk_out(vk_out), .pc_out(pc_out),
        .imm_out(imm_out), .dest_out(dest_out), .count(count)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the edge, outputs are sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest);
        issue_valid = 1'b1;
        op_in = op; vj_in = vj; vk_in = vk; qj_in = qj; qk_in = qk; dest_in = dest;
        pc_in = 32'h100 + 32'(op); imm_in = 32'h20 + 32'(op);
    endtask

    task automatic cdb_clear();
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; fu_ready = 1'b0;
        op_in = '0; qj_in = '0; qk_in = '0; dest_in = '0;
        vj_in = '0; vk_in = '0; pc_in = '0; imm_in = '0;
        cdb_clear();
        step(); step();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_vj_out", vj_out, 0);
        chk("rst_issue_ready", issue_ready, 1);

        // Ready-at-issue op dispatches the cycle after issue
        fu_ready = 1'b1;
        issue(4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 4'd1);
        step();
        issue_valid = 1'b0;
        chk("basic_count_1", count, 1);
        chk("basic_no_disp_yet", disp_valid, 0);
        step();
        chk("basic_disp_valid", disp_valid, 1);
        chk("basic_op", op_out, 3);
        chk("basic_vj", vj_out, 5);
        chk("basic_vk", vk_out, 7);
        chk("basic_pc", pc_out, 32'h103);
        chk("basic_dest", dest_out, 1);
        chk("basic_count_0", count, 0);
        step();
        chk("basic_idle_valid", disp_valid, 0);
        chk("basic_idle_vj", vj_out, 0);

        // Wakeup on CDB channel 1 two cycles after issue
        issue(4'd4, 32'd0, 32'd3, 4'd6, 4'd0, 4'd2);
        step();
        issue_valid = 1'b0;
        step();
        chk("wake_wait", disp_valid, 0);
        cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_data = {32'h55, 32'h0};
        step();
        cdb_clear();
        chk("wake_edge_no_disp", disp_valid, 0);
        step();
        chk("wake_disp_valid", disp_valid, 1);
        chk("wake_vj", vj_out, 32'h55);
        chk("wake_vk", vk_out, 3);
        step();

        // Issue-time bypass on qk from channel 0
        issue(4'd5, 32'd1, 32'h11, 4'd0, 4'd9, 4'd3);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = {32'h0, 32'hAA};
        step();
        issue_valid = 1'b0; cdb_clear();
        chk("byp_count", count, 1);
        step();
        chk("byp_disp_valid", disp_valid, 1);
        chk("byp_vk", vk_out, 32'hAA);
        step();

        // Same tag on both channels: channel 0 wins
        issue(4'd6, 32'd0, 32'd0, 4'd7, 4'd0, 4'd4);
        step();
        issue_valid = 1'b0;
        cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_data = {32'h71, 32'h70};
        step();
        cdb_clear();
        step();
        chk("prio_vj", vj_out, 32'h70);
        step();

        // Oldest-first ordering once A wakes
        fu_ready = 1'b0;
        issue(4'd1, 32'd0, 32'd0, 4'd2, 4'd0, 4'd3); step();
        issue(4'd2, 32'd0, 32'd0, 4'd0, 4'd0, 4'd4); step();
        issue(4'd3, 32'd0, 32'd0, 4'd0, 4'd0, 4'd5); step();
        issue_valid = 1'b0;
        chk("order_count", count, 3);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_data = {32'h0, 32'h22};
        step();
        cdb_clear();
        fu_ready = 1'b1;
        step();
        chk("order_a_op", op_out, 1);
        chk("order_a_vj", vj_out, 32'h22);
        step();
        chk("order_b_op", op_out, 2);
        step();
        chk("order_c_op", op_out, 3);
        step();
        chk("order_done_valid", disp_valid, 0);
        chk("order_done_count", count, 0);

        // Full station: fifth issue ignored, freed slot visible next cycle
        fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(4'(4 + i), 32'd0, 32'd0, 4'd0, 4'd0, 4'(i));
            step();
        end
        chk("full_ready", issue_ready, 0);
        chk("full_count", count, 4);
        issue(4'd8, 32'd0, 32'd0, 4'd0, 4'd0, 4'd9);
        step();
        issue_valid = 1'b0;
        chk("full_ignored_count", count, 4);
        fu_ready = 1'b1;
        step();
        fu_ready = 1'b0;
        chk("full_disp_op", op_out, 4);
        chk("full_count_3", count, 3);
        chk("full_ready_again", issue_ready, 1);
        fu_ready = 1'b1;
        step(); chk("full_drain_5", op_out, 5);
        step(); chk("full_drain_6", op_out, 6);
        step(); chk("full_drain_7", op_out, 7);
        step();
        chk("full_no_op8", disp_valid, 0);
        chk("full_empty", count, 0);

        // Flush with concurrent issue drops everything
        fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(4'(1 + i), 32'd0, 32'd0, 4'd0, 4'd0, 4'd0);
            step();
        end
        chk("flush_pre_count", count, 3);
        fu_ready = 1'b1;
        flush = 1'b1;
        issue(4'hF, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0);
        step();
        flush = 1'b0; issue_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_disp_valid", disp_valid, 0);
        step();
        chk("flush_no_disp", disp_valid, 0);
        chk("flush_op_out", op_out, 0);

        // Reset mid-operation discards pending entry
        fu_ready = 1'b0;
        issue(4'd9, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0);
        step();
        issue_valid = 1'b0;
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_ready", issue_ready, 1);
        fu_ready = 1'b1;
        step();
        chk("midrst_no_disp", disp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rs_param.md
RS_PARAM -- requirements
Module: rs_param

Interface
REQ-001 SHALL have parameter N_ENTRY, default 4: number of reservation-station entries (2..16).
REQ-002 SHALL have parameter OP_W, default 4: operation field width.
REQ-003 SHALL have parameter ROB_W, default 4: ROB tag width; tag 0 means "operand ready".
REQ-004 SHALL have parameter DATA_W, default 32: operand, PC and immediate width.
REQ-005 SHALL have parameter N_CDB, default 2: number of common-data-bus broadcast channels.
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: flush in 1, discard all entries; issue_valid in 1; issue_ready out 1, high when at least one entry is free.
REQ-008 SHALL have ports: op_in in OP_W; vj_in, vk_in, pc_in, imm_in in DATA_W; qj_in, qk_in, dest_in in ROB_W.
REQ-009 SHALL have ports: cdb_valid in N_CDB; cdb_tag in N_CDB*ROB_W; cdb_data in N_CDB*DATA_W, with channel c in slice c.
REQ-010 SHALL have ports: fu_ready in 1, the functional unit accepts a dispatch this cycle.
REQ-011 SHALL have ports: disp_valid out 1; op_out out OP_W; vj_out, vk_out, pc_out, imm_out out DATA_W; dest_out out ROB_W, all registered.
REQ-012 SHALL have port count out clog2(N_ENTRY+1), the number of busy entries.

Function
REQ-013 Each entry SHALL hold busy, op, vj, vk, qj, qk, pc, imm, dest and an age counter.
REQ-014 issue_ready SHALL be combinational: high iff any entry is not busy at the start of the cycle.
REQ-015 Issue with issue_valid&issue_ready SHALL write the lowest-index free entry: busy=1, age=0, fields from the inputs.
REQ-016 Issue with issue_valid while issue_ready=0 SHALL be ignored, with no state change.
REQ-017 Issue bypass: when qj_in!=0 and it matches a valid CDB channel in the same cycle, the entry SHALL store vj=that channel's data and qj=0; the same rule applies to qk.
REQ-018 Wakeup: for each busy entry with qj!=0 that matches a valid cdb_tag, the entry SHALL set vj=cdb_data and qj=0 at the clock edge; the same rule applies to qk; cdb_tag==0 SHALL never match.
REQ-019 When several CDB channels carry the same tag, the lowest channel index SHALL win.
REQ-020 Readiness: an entry SHALL be ready when busy&&qj==0&&qk==0 using registered state; an entry woken this cycle SHALL be eligible next cycle.
REQ-021 Selection SHALL pick the ready entry with the largest age, with ties going to the lowest index.
REQ-022 Dispatch: when fu_ready=1 and a ready entry exists, the following SHALL occur at the edge:
- the selected fields are registered onto the outputs;
- disp_valid=1;
- the entry's busy is cleared.
REQ-023 In cycles without a dispatch, disp_valid SHALL be 0 and all data outputs SHALL be 0.
REQ-024 Dispatch latency SHALL be 1 cycle: an entry ready in cycle t appears on the outputs after edge t.
REQ-025 Age: on every accepted issue, each other busy entry SHALL increment its age, saturating at N_ENTRY-1; age SHALL be unchanged otherwise.
REQ-026 An entry freed by dispatch SHALL NOT be reused by an issue in the same cycle; it is free from the next cycle.
REQ-027 Simultaneous issue, wakeup and dispatch SHALL all take effect in the same edge on distinct entries.
REQ-028 count SHALL equal the number of busy entries, registered.
REQ-029 flush SHALL take priority over issue, wakeup and dispatch:
- all busy bits are cleared;
- disp_valid=0 and outputs=0 at the next edge;
- the issue in the same cycle is dropped.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL clear every entry field, busy and age to 0.
REQ-031 When rst=1 at a clock edge, the block SHALL set disp_valid and all outputs to 0 and count=0.
REQ-032 rst SHALL dominate flush and all other inputs; rst asserted mid-operation SHALL discard pending entries.
REQ-033 After reset deasserts, issue_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Bench SHALL cover: issue op=3, vj=5, vk=7, qj=qk=0, fu_ready=1 -> disp_valid=1 next cycle with vj_out=5, vk_out=7; count returns to 0.
REQ-035 Bench SHALL cover: issue qj=6; two cycles later cdb_valid[1]=1, tag=6, data=0x55 -> dispatch one cycle after wakeup with vj_out=0x55.
REQ-036 Bench SHALL cover: issue qk=9 while CDB ch0 broadcasts tag 9, data 0xAA in the same cycle -> entry ready, dispatched next cycle with vk_out=0xAA.
REQ-037 Bench SHALL cover: hold fu_ready=0, issue A(qj=2), B, C ready, then wake A, set fu_ready=1 -> dispatch order A, B, C (oldest first).
REQ-038 Bench SHALL cover: fill 4 entries -> issue_ready=0, count=4; a fifth issue is ignored; one dispatch -> issue_ready=1 next cycle.
REQ-039 Bench SHALL cover: 3 busy entries, assert flush together with issue_valid -> count=0, disp_valid=0, the issued op is never dispatched.
